uart_tx_frame: RTL

Parametrised UART transmitter: the successor to our fixed 8N1 transmitter. It buffers bytes in a small TX FIFO and serialises each one as a start bit, DBIT data bits (LSB first), an optional even/odd parity bit, and 1, 1.5 or 2 stop bits. Bit timing comes from the shared baud-rate generator's `s_tick` strobe. The block sits between the MIPS debug/IO bus interface and the `tx` pin.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync_fifo.sv | 48 ++++
 rtl/uart_tx_frame.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings plus parity and stop-length mode codes,
// common to the TX framer and the future RX framer.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam logic [1:0] STOP_1   = 2'b00;
    localparam logic [1:0] STOP_1P5 = 2'b01;
    localparam logic [1:0] STOP_2   = 2'b10;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO, depth 2^AW, with registered full/empty flags.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2**AW];
    logic [AW:0]      wptr, rptr, wptr_n, rptr_n;
    logic             do_push, do_pop;

    // Flags are the pre-edge registered values, so a push into a full FIFO is
    // dropped even when a pop happens on the same edge.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign wptr_n  = wptr + {{AW{1'b0}}, do_push};
    assign rptr_n  = rptr + {{AW{1'b0}}, do_pop};
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            wptr  <= wptr_n;
            rptr  <= rptr_n;
            empty <= (wptr_n == rptr_n);
            full  <= (wptr_n[AW] != rptr_n[AW]) && (wptr_n[AW-1:0] == rptr_n[AW-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: FIFO-buffered words framed as start, DBIT data
// bits LSB first, optional parity and 1/1.5/2 stop bits, timed by s_tick.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int OVS     = 16,
    parameter int FIFO_AW = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            wr_en,
    input  logic [DBIT-1:0] data_in,
    input  logic [1:0]      parity_mode,
    input  logic [1:0]      stop_mode,
    output logic            full,
    output logic            empty,
    output logic            overflow,
    output logic            busy,
    output logic            tx
);

    localparam int SW = $clog2(2 * OVS);
    localparam int NW = $clog2(DBIT);

    uart_state_t     state, state_n;
    logic [SW-1:0]   s, s_n, stop_last;
    logic [NW-1:0]   n, n_n;
    logic [DBIT-1:0] sreg, sreg_n, fifo_dout;
    logic            tx_n, pop, bit_end, stop_end, last_bit;
    logic            par_en, par_bit;
    logic [1:0]      stop_sel;

    uart_sync_fifo #(.WIDTH(DBIT), .AW(FIFO_AW)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_en),
        .wdata (data_in),
        .pop   (pop),
        .rdata (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        case (stop_sel)
            STOP_1P5: stop_last = SW'(3 * OVS / 2 - 1);
            STOP_2:   stop_last = SW'(2 * OVS - 1);
            default:  stop_last = SW'(OVS - 1);
        endcase
    end

    assign bit_end  = s_tick && (s == SW'(OVS - 1));
    assign stop_end = s_tick && (s == stop_last);
    assign last_bit = (n == NW'(DBIT - 1));
    assign busy     = (state != ST_IDLE) | ~empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:   if (!empty)              state_n = ST_START;
            ST_START:  if (bit_end)             state_n = ST_DATA;
            ST_DATA:   if (bit_end && last_bit) state_n = par_en ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_end)             state_n = ST_STOP;
            ST_STOP:   if (stop_end)            state_n = ST_IDLE;
            default:                            state_n = ST_IDLE;
        endcase
    end

    // tx_n is the level the line takes after this edge, so tx stays a flop.
    always_comb begin
        pop    = 1'b0;
        s_n    = s;
        n_n    = n;
        sreg_n = sreg;
        tx_n   = tx;
        case (state)
            ST_IDLE: begin
                tx_n = 1'b1;
                if (!empty) begin
                    pop    = 1'b1;
                    s_n    = '0;
                    n_n    = '0;
                    sreg_n = fifo_dout;
                    tx_n   = 1'b0;
                end
            end
            ST_START: if (s_tick) begin
                s_n = bit_end ? '0 : s + 1'b1;
                if (bit_end) tx_n = sreg[0];
            end
            ST_DATA: if (s_tick) begin
                s_n = bit_end ? '0 : s + 1'b1;
                if (bit_end) begin
                    sreg_n = sreg >> 1;
                    n_n    = n + 1'b1;
                    tx_n   = last_bit ? (par_en ? par_bit : 1'b1) : sreg[1];
                end
            end
            ST_PARITY: if (s_tick) begin
                s_n = bit_end ? '0 : s + 1'b1;
                if (bit_end) tx_n = 1'b1;
            end
            ST_STOP: if (s_tick) begin
                s_n  = stop_end ? '0 : s + 1'b1;
                tx_n = 1'b1;
            end
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s        <= '0;
            n        <= '0;
            sreg     <= '0;
            tx       <= 1'b1;
            par_en   <= 1'b0;
            par_bit  <= 1'b0;
            stop_sel <= STOP_1;
            overflow <= 1'b0;
        end else begin
            s        <= s_n;
            n        <= n_n;
            sreg     <= sreg_n;
            tx       <= tx_n;
            overflow <= wr_en & full;
            // Frame configuration is frozen at pop time.
            if (pop) begin
                par_en   <= (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
                par_bit  <= (^fifo_dout) ^ (parity_mode == PAR_ODD);
                stop_sel <= stop_mode;
            end
        end
    end

endmodule
